// File: rtl/lif_param_loader.sv
// lif_param_loader: byte-serial framed loader that commits LIF neuron parameters atomically (checksum byte enabled by LIF_PARAM_CHECKSUM_EN)
module lif_param_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  HEADER         = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [2:0] weight_a,
    output logic [2:0] weight_b,
    output logic [7:0] leak_rate,
    output logic [7:0] threshold,
    output logic [3:0] leak_cycles,
    output logic       params_ready,
    output logic       load_done,
    output logic       load_err,
    output logic       busy
);
`ifdef LIF_PARAM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, B1, B2, B3, B4, CSUM, COMMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, B1, B2, B3, B4, COMMIT} state_t;
`endif
    localparam logic [7:0] LAST_GAP = 8'(TIMEOUT_CYCLES - 1);
    state_t     state_q, state_d;
    logic [7:0] gap_q, gap_d;
    logic       err_q, err_d, done_q, pr_q;
    logic       xfer;
    logic [2:0] sh_wa_q, sh_wb_q, wa_q, wb_q;
    logic [7:0] sh_lr_q, sh_th_q, lr_q, th_q;
    logic [3:0] sh_lc_q, lc_q;
`ifdef LIF_PARAM_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
`endif
    assign data_ready   = !reset && state_q != COMMIT;
    assign xfer         = data_valid && data_ready;
    assign busy         = state_q != IDLE;
    assign weight_a     = wa_q;
    assign weight_b     = wb_q;
    assign leak_rate    = lr_q;
    assign threshold    = th_q;
    assign leak_cycles  = lc_q;
    assign params_ready = pr_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    // frame sequencing, error detection and inter-byte gap timeout; an accepted byte always beats expiry
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        gap_d   = 8'd0;
`ifdef LIF_PARAM_CHECKSUM_EN
        xor_d   = (state_q == IDLE) ? 8'd0 : xor_q;
`endif
        case (state_q)
            IDLE: if (xfer) begin
                state_d = (data_in == HEADER) ? B1 : IDLE;
                err_d   = data_in != HEADER;
            end
            B1: if (xfer) state_d = B2;
            B2: if (xfer) state_d = B3;
            B3: if (xfer) state_d = B4;
`ifdef LIF_PARAM_CHECKSUM_EN
            B4: if (xfer) state_d = CSUM;
            CSUM: if (xfer) begin
                state_d = (data_in == xor_q) ? COMMIT : IDLE;
                err_d   = data_in != xor_q;
            end
`else
            B4: if (xfer) state_d = COMMIT;
`endif
            default: state_d = IDLE;
        endcase
        if (busy && state_q != COMMIT && !xfer) begin
            gap_d = gap_q + 8'd1;
            if (gap_q == LAST_GAP) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
`ifdef LIF_PARAM_CHECKSUM_EN
        if (xfer && state_q inside {B1, B2, B3, B4}) xor_d = xor_q ^ data_in;
`endif
    end
    // state, gap counter and registered status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= 8'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            done_q  <= state_q == COMMIT;
        end
    end
`ifdef LIF_PARAM_CHECKSUM_EN
    // running XOR of payload bytes for the checksum compare
    always_ff @(posedge clk) begin
        if (reset) xor_q <= 8'd0;
        else xor_q <= xor_d;
    end
`endif
    // shadow registers capture payload fields and are discarded on any rejection
    always_ff @(posedge clk) begin
        if (reset || err_d) begin
            sh_wa_q <= 3'd0;
            sh_wb_q <= 3'd0;
            sh_lr_q <= 8'd0;
            sh_th_q <= 8'd0;
            sh_lc_q <= 4'd0;
        end else if (xfer) begin
            if (state_q == B1) begin
                sh_wa_q <= data_in[2:0];
                sh_wb_q <= data_in[6:4];
            end
            if (state_q == B2) sh_lr_q <= data_in;
            if (state_q == B3) sh_th_q <= data_in;
            if (state_q == B4) sh_lc_q <= data_in[3:0];
        end
    end
    // neuron-facing outputs change only on commit so a reload or abort never disturbs them
    always_ff @(posedge clk) begin
        if (reset) begin
            wa_q <= 3'd0;
            wb_q <= 3'd0;
            lr_q <= 8'd0;
            th_q <= 8'hFF;
            lc_q <= 4'd0;
            pr_q <= 1'b0;
        end else if (state_q == COMMIT) begin
            wa_q <= sh_wa_q;
            wb_q <= sh_wb_q;
            lr_q <= sh_lr_q;
            th_q <= sh_th_q;
            lc_q <= sh_lc_q;
            pr_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lif_param_loader.sv
// tb_lif_param_loader: directed scoreboard bench for lif_param_loader (follows LIF_PARAM_CHECKSUM_EN)
module tb_lif_param_loader;
    logic       clk = 1'b0, reset = 1'b1, data_valid = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_ready, params_ready, load_done, load_err, busy;
    logic [2:0] weight_a, weight_b;
    logic [7:0] leak_rate, threshold;
    logic [3:0] leak_cycles;

    typedef struct {
        logic       is_err;
        logic [2:0] wa, wb;
        logic [7:0] lr, th;
        logic [3:0] lc;
        logic       pr;
    } exp_t;

    exp_t sb[$];
    exp_t cur, rst_val, mon_e;
    int   vectors = 0, miscompares = 0;

    lif_param_loader dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .weight_a(weight_a), .weight_b(weight_b),
        .leak_rate(leak_rate), .threshold(threshold), .leak_cycles(leak_cycles),
        .params_ready(params_ready), .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        check({tag, ".weight_a"}, 32'(weight_a), 32'(e.wa));
        check({tag, ".weight_b"}, 32'(weight_b), 32'(e.wb));
        check({tag, ".leak_rate"}, 32'(leak_rate), 32'(e.lr));
        check({tag, ".threshold"}, 32'(threshold), 32'(e.th));
        check({tag, ".leak_cycles"}, 32'(leak_cycles), 32'(e.lc));
        check({tag, ".params_ready"}, 32'(params_ready), 32'(e.pr));
    endtask

    // pop one expectation for every done/err pulse; extra or long pulses find an empty queue
    always @(negedge clk) begin
        if (!reset && (load_done || load_err)) begin
            if (sb.size() == 0) check("unexpected_pulse", 32'({load_done, load_err}), 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("pulse_err", 32'(load_err), 32'(mon_e.is_err));
                check("pulse_done", 32'(load_done), 32'(!mon_e.is_err));
                cmp_out(mon_e.is_err ? "after_err" : "after_commit", mon_e);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (!data_ready && n < 20) begin
            cyc(1);
            n++;
        end
        if (!data_ready) check("ready_wait", 32'(data_ready), 32'd1);
        cyc(1);
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            cyc(1);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic frame(input logic [7:0] b1, b2, b3, b4, input bit bad, input int gap, input bit thr);
        logic [7:0] bytes[6];
        exp_t old, e;
        int nb;
        old = cur;
        bytes[0] = 8'hA5;
        bytes[1] = b1;
        bytes[2] = b2;
        bytes[3] = b3;
        bytes[4] = b4;
        bytes[5] = b1 ^ b2 ^ b3 ^ b4 ^ (bad ? 8'h01 : 8'h00);
`ifdef LIF_PARAM_CHECKSUM_EN
        nb = 6;
`else
        nb = 5;
`endif
        if (bad) e = '{1'b1, cur.wa, cur.wb, cur.lr, cur.th, cur.lc, cur.pr};
        else begin
            e   = '{1'b0, b1[2:0], b1[6:4], b2, b3, b4[3:0], 1'b1};
            cur = '{1'b0, b1[2:0], b1[6:4], b2, b3, b4[3:0], 1'b1};
        end
        sb.push_back(e);
        for (int i = 0; i < nb; i++) begin
            send(bytes[i]);
            if (i == 1 && gap > 0) cyc(gap);
            if (thr && i < nb - 1) begin
                cmp_out("hold_busy", old);
                cyc(1);
                cmp_out("hold_gap", old);
            end
        end
    endtask

    initial begin
        rst_val = '{1'b0, 3'd0, 3'd0, 8'd0, 8'hFF, 4'd0, 1'b0};
        cur     = rst_val;
        cyc(3);
        check("reset.data_ready", 32'(data_ready), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.load_done", 32'(load_done), 32'd0);
        check("reset.load_err", 32'(load_err), 32'd0);
        cmp_out("reset", rst_val);
        reset = 1'b0;
        #1;
        check("post_reset.data_ready", 32'(data_ready), 32'd1);
`ifdef LIF_PARAM_CHECKSUM_EN
        frame(8'h53, 8'h02, 8'h40, 8'h03, 1'b1, 0, 1'b0);
        drain();
        cmp_out("bad_csum", rst_val);
`endif
        frame(8'h53, 8'h02, 8'h40, 8'h03, 1'b0, 0, 1'b0);
        check("latency.done_early", 32'(load_done), 32'd0);
        check("latency.pr_early", 32'(params_ready), 32'd0);
        cyc(1);
        check("latency.done", 32'(load_done), 32'd1);
        cmp_out("commit1", '{1'b0, 3'd3, 3'd5, 8'h02, 8'h40, 4'd3, 1'b1});
        cyc(1);
        check("latency.done_once", 32'(load_done), 32'd0);
        drain();
        sb.push_back('{1'b1, cur.wa, cur.wb, cur.lr, cur.th, cur.lc, cur.pr});
        send(8'h5A);
        check("bad_hdr.busy", 32'(busy), 32'd0);
        drain();
        frame(8'hF7, 8'h10, 8'h20, 8'hF9, 1'b0, 0, 1'b0);
        drain();
        sb.push_back('{1'b1, cur.wa, cur.wb, cur.lr, cur.th, cur.lc, cur.pr});
        send(8'hA5);
        send(8'h53);
        cyc(254);
        check("timeout.busy_before", 32'(busy), 32'd1);
        check("timeout.err_before", 32'(load_err), 32'd0);
        cyc(1);
        check("timeout.err", 32'(load_err), 32'd1);
        check("timeout.busy_after", 32'(busy), 32'd0);
        drain();
        frame(8'h26, 8'h11, 8'h33, 8'h05, 1'b0, 254, 1'b0);
        drain();
        frame(8'h21, 8'h05, 8'h80, 8'h07, 1'b0, 0, 1'b1);
        drain();
        cmp_out("throttled", '{1'b0, 3'd1, 3'd2, 8'h05, 8'h80, 4'd7, 1'b1});
        send(8'hA5);
        send(8'h53);
        send(8'h02);
        reset = 1'b1;
        cyc(1);
        check("mid_reset.data_ready", 32'(data_ready), 32'd0);
        check("mid_reset.busy", 32'(busy), 32'd0);
        cmp_out("mid_reset", rst_val);
        reset = 1'b0;
        cur   = rst_val;
        #1;
        frame(8'h53, 8'h02, 8'h40, 8'h03, 1'b0, 0, 1'b0);
        frame(8'h44, 8'h9C, 8'h7E, 8'h0A, 1'b0, 0, 1'b0);
        drain();
        cmp_out("back_to_back", '{1'b0, 3'd4, 3'd4, 8'h9C, 8'h7E, 4'hA, 1'b1});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lif_param_loader.md
# lif_param_loader

Byte-serial configuration loader that drives the weight, leak, threshold and `params_ready` inputs of the dual-input LIF neuron. It accepts a framed packet over a valid/ready byte stream and stages the fields in shadow registers. On a complete, valid frame it commits all fields to the neuron atomically. Malformed or stalled frames are rejected, and the neuron keeps its previous parameters.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum idle cycles allowed between bytes inside a frame; 8-bit range, must be ≥1.
- `HEADER`, default 8'hA5: frame start byte.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  8  packet byte
- `data_valid`  in  1  `data_in` is valid this cycle
- `data_ready`  out  1  loader accepts a byte this cycle
- `weight_a`  out  3  channel A weight to neuron
- `weight_b`  out  3  channel B weight to neuron
- `leak_rate`  out  8  leak subtrahend
- `threshold`  out  8  spike threshold
- `leak_cycles`  out  4  leak period
- `params_ready`  out  1  committed parameter set is valid
- `load_done`  out  1  one-cycle pulse per successful commit
- `load_err`  out  1  one-cycle pulse per rejected frame
- `busy`  out  1  frame in progress (any state except IDLE)

## Operation
- Frame format:
  - Byte 0: `HEADER`.
  - Byte 1: [2:0]=`weight_a`, [6:4]=`weight_b`; bits 3 and 7 are ignored.
  - Byte 2: `leak_rate`.
  - Byte 3: `threshold`.
  - Byte 4: [3:0]=`leak_cycles`; [7:4] are ignored.
  - Byte 5 (checksum build only): XOR of bytes 1–4.
- Handshake: a byte transfers on any rising edge where `data_valid && data_ready`. `data_ready` is 1 in IDLE, B1, B2, B3, B4 and CSUM. It is 0 in COMMIT and during reset.
- FSM states: IDLE → B1 → B2 → B3 → B4 → (CSUM) → COMMIT → IDLE.
  - IDLE: an accepted byte equal to `HEADER` moves to B1. Any other accepted byte is dropped and pulses `load_err`; the FSM stays in IDLE.
  - B1..B4: each accepted byte is stored in its shadow register and the FSM advances.
  - CSUM: the accepted byte is compared with the running XOR. On match go to COMMIT. On mismatch pulse `load_err` and return to IDLE.
  - COMMIT: copy the shadow registers to the outputs, set `params_ready`=1, pulse `load_done`, return to IDLE.
- Running XOR: cleared in IDLE and updated with each byte accepted in B1..B4.
- Timeout: an 8-bit gap counter clears on every accepted byte and on entry to B1. It increments each cycle in B1..CSUM with no transfer. When it reaches `TIMEOUT_CYCLES`, the loader pulses `load_err`, discards the shadow registers and returns to IDLE. Only an accepted byte clears the counter; a stalled `data_valid` does not.
- Output registers change only in COMMIT.
  - During a reload, the old values and `params_ready`=1 stay stable.
  - An aborted frame never alters the outputs.
- Once set, `params_ready` clears only on `reset`.
- Simultaneous timeout expiry and byte acceptance in the same cycle: the byte wins, the counter clears and no error is raised.

## Timing
- Reset values:
  - `weight_a`=0, `weight_b`=0, `leak_rate`=0.
  - `threshold`=8'hFF, `leak_cycles`=0.
  - `params_ready`=0, `load_done`=0, `load_err`=0, `busy`=0.
  - `data_ready`=0 while `reset` is high; 1 on the first cycle after reset.
- Reset mid-frame: the FSM returns to IDLE, shadow registers and the running XOR clear, and `params_ready` drops to 0.
- Commit latency: last byte accepted at edge N → FSM in COMMIT after N. At edge N+1, the outputs update, `params_ready` rises and `load_done` is high for exactly one cycle.
- The `load_err` pulse is registered: it is high for the cycle after the edge on which the error was detected.
- Minimum frame time is 7 cycles with checksum (6 byte transfers + COMMIT) and 6 without.
- Back-to-back frames: the header of the next frame may be accepted on the cycle right after COMMIT.

## Configuration
- `LIF_PARAM_CHECKSUM_EN` defined:
  - The CSUM state exists and frames are 6 bytes.
  - A checksum mismatch pulses `load_err` and leaves the outputs unchanged.
- `LIF_PARAM_CHECKSUM_EN` not defined:
  - The CSUM state and the XOR logic are removed.
  - B4 goes directly to COMMIT and frames are 5 bytes.
  - `load_err` is raised only by a bad header or a timeout.

## Test plan
- Reset, then send A5,53,02,40,03,12 with `data_valid` held high (checksum build): outputs become `weight_a`=3, `weight_b`=5, `leak_rate`=2, `threshold`=0x40, `leak_cycles`=3; `params_ready`=1 and `load_done` is a single one-cycle pulse.
- Same frame with checksum 0x13: one `load_err` pulse, outputs still at reset values, `params_ready`=0.
- Send byte 0x5A in IDLE: `load_err` pulses and the FSM stays in IDLE. A valid frame sent afterwards commits normally.
- Send A5,53, then hold `data_valid`=0 for 255 cycles: `load_err` pulses at the timeout and `busy` drops. With a gap of 254 cycles followed by the rest of the frame, the frame commits with no error.
- After a committed frame, send a second frame with `threshold`=0x80 and throttle `data_valid` at 50 %: the old outputs hold with `params_ready`=1 until the new commit, then all fields update on the same edge.
- Assert `reset` while in B3: all outputs return to their reset values next cycle and `params_ready`=0; a following full frame commits correctly.
